sampler_fifo: RTL and testbench
===============================

Name: sampler_fifo

Overview:
- Parametrised successor to the single-register audio sampler.
- Accepts PCM codes from the synth through a valid/ready handshake and buffers them in a FIFO of FIFO_DEPTH entries.
- Pops one code per sample period (CLK_DIV cycles) and drives an internal first-order sigma-delta modulator of width CODE_WIDTH.
- Adds runtime enable, underrun detection with a selectable underrun policy, and a fill-level output for the upstream rate controller.

Parameters:
CODE_WIDTH, 10, width of sample codes and of the sigma-delta datapath
CLK_DIV, 2500, clocks per sample period; legal range is 2 or more
FIFO_DEPTH, 8, FIFO entries; power of two, 2 or more
UNDERRUN_HOLD, 1, 1 = hold the last code on underrun; 0 = load mid-scale 2^(CODE_WIDTH-1)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  reset; asynchronous assert, active-low (0 = reset)
enable  in  1  1 = run the sample clock and pops; 0 = pause
in_valid  in  1  in_code is valid
in_code  in  CODE_WIDTH  sample code, unsigned, offset binary
in_ready  out  1  FIFO can accept a code this cycle
fill_level  out  clog2(FIFO_DEPTH)+1  number of entries currently held
sample_tick  out  1  one-cycle pulse at the sample-period boundary
underrun  out  1  one-cycle pulse when a tick finds the FIFO empty
underrun_count  out  16  saturating count of underruns
pwm_out  out  1  registered sigma-delta output bit

Behaviour:
- Reset (rst=0, asynchronous):
  - Clears the divider counter, FIFO pointers, fill_level, current_code, accumulator, underrun_count, sample_tick, underrun and pwm_out (all 0).
  - in_ready is 0 while rst=0.
  - The first cycle after release is normal operation; in_ready=1 then.
- Divider:
  - cnt counts 0..CLK_DIV-1 and wraps to 0.
  - sample_tick is registered: it is 1 in the cycle after cnt==CLK_DIV-1 with enable=1.
  - With enable=0, cnt holds its value, sample_tick stays 0 and no pops occur.
  - The FIFO still accepts pushes while enable=0.
- Push:
  - in_ready = (fill_level != FIFO_DEPTH), derived from registered count only.
  - A push occurs on in_valid && in_ready.
  - While full, in_valid is ignored; in_code must be held by the source (standard valid/ready rules).
- Pop:
  - Occurs on the internal tick condition (cnt==CLK_DIV-1 && enable) when fill_level != 0.
  - The head entry loads into current_code at that edge.
- Underrun:
  - Occurs when the tick condition meets fill_level==0.
  - current_code holds if UNDERRUN_HOLD=1, else loads 2^(CODE_WIDTH-1).
  - underrun pulses for 1 cycle, aligned with sample_tick.
  - underrun_count increments and saturates at 16'hFFFF.
- Simultaneous push and tick:
  - Empty FIFO: the tick is an underrun; the pushed code is stored and fill_level becomes 1.
  - Non-empty FIFO: push and pop both occur; fill_level is unchanged.
  - Full FIFO: no push (in_ready=0); the pop occurs, so fill_level=FIFO_DEPTH-1 and in_ready=1 the next cycle.
- Pointers: wrap modulo FIFO_DEPTH; fill_level is a separate up/down counter.
- Sigma-delta modulator:
  - acc is CODE_WIDTH+1 bits, updated every cycle regardless of enable.
  - acc <= {1'b0, acc[CODE_WIDTH-1:0]} + current_code.
  - pwm_out <= carry bit acc[CODE_WIDTH] of the new sum.
  - Ones density over 2^CODE_WIDTH cycles equals current_code / 2^CODE_WIDTH exactly.
  - A code loaded at edge N affects pwm_out from edge N+1.
- Latency: a code pushed into an empty FIFO is output at the first tick at least one cycle after the push.

Test Plan:
Parameters for all scenarios: CODE_WIDTH=4, CLK_DIV=8, FIFO_DEPTH=4, UNDERRUN_HOLD=1 unless stated.
1. Reset then idle, enable=1, no pushes -> pwm_out=0 throughout; underrun pulse every 8 cycles; underrun_count=3 after 24 cycles; in_ready=1.
2. Push 8, enable, observe 32 cycles after the load -> pwm_out high on exactly 16 cycles (alternating); push 15 -> 15 of 16 cycles high; push 0 -> never high.
3. Push 5 codes back-to-back with enable=0 -> first 4 accepted, fill_level=4, in_ready=0 on the 5th cycle; enable=1 -> one pop at the first tick, fill_level=3, in_ready=1.
4. Empty FIFO, push code 3 in the exact tick cycle -> underrun=1 and count +1; fill_level=1; code 3 reaches current_code at the next tick, 8 cycles later.
5. UNDERRUN_HOLD=0, after code 12 drain the FIFO -> next tick loads 8; pwm density 1/2; underrun_count increments.
6. Assert rst mid-period with 3 entries queued -> all outputs 0 immediately (asynchronously); after release fill_level=0 and the first tick occurs 8 cycles later as an underrun.

Source files
------------

// File: rtl/sampler_fifo.sv
// Buffered audio sampler: valid/ready FIFO of PCM codes, popped once per sample
// period into a first-order sigma-delta modulator driving a 1-bit output.
module sampler_fifo #(
    parameter int CODE_WIDTH    = 10,
    parameter int CLK_DIV       = 2500,
    parameter int FIFO_DEPTH    = 8,
    parameter int UNDERRUN_HOLD = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          in_valid,
    input  logic [CODE_WIDTH-1:0]         in_code,
    output logic                          in_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          sample_tick,
    output logic                          underrun,
    output logic [15:0]                   underrun_count,
    output logic                          pwm_out
);

    localparam int CNT_W  = $clog2(CLK_DIV);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [FILL_W-1:0]     FILL_FULL = FILL_W'(FIFO_DEPTH);
    localparam logic [CODE_WIDTH-1:0] MID_CODE  = {1'b1, {(CODE_WIDTH-1){1'b0}}};

    logic [CNT_W-1:0]      cnt_r;
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [FILL_W-1:0]     fill_r;
    logic [CODE_WIDTH-1:0] cur_code_r;
    logic [CODE_WIDTH-1:0] acc_r;
    logic [15:0]           ucnt_r;
    logic                  tick_r;
    logic                  under_r;
    logic                  pwm_r;
    logic [CODE_WIDTH-1:0] mem_r [FIFO_DEPTH];

    logic                  tick_s;
    logic                  empty_s;
    logic                  ready_s;
    logic                  push_s;
    logic                  pop_s;
    logic [CODE_WIDTH:0]   sum_s;
    logic [FILL_W-1:0]     fill_next_s;

    // Handshake, tick and occupancy decisions for the coming edge
    always_comb begin
        tick_s  = enable && (cnt_r == CNT_LAST);
        empty_s = (fill_r == {FILL_W{1'b0}});
        if (rst && (fill_r != FILL_FULL)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        push_s = in_valid && ready_s;
        pop_s  = tick_s && !empty_s;
        // carry out of the low CODE_WIDTH bits is the modulator output
        sum_s  = {1'b0, acc_r} + {1'b0, cur_code_r};
        if (push_s && !pop_s) begin
            fill_next_s = fill_r + FILL_W'(1);
        end else if (pop_s && !push_s) begin
            fill_next_s = fill_r - FILL_W'(1);
        end else begin
            fill_next_s = fill_r;
        end
    end

    // Sample-period divider, frozen while paused
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (enable) begin
            cnt_r <= (cnt_r == CNT_LAST) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // FIFO pointers and fill counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            fill_r   <= {FILL_W{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            fill_r <= fill_next_s;
        end
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) mem_r[wr_ptr_r] <= in_code;
    end

    // Per-tick code load, underrun pulse and saturating underrun counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_code_r <= {CODE_WIDTH{1'b0}};
            tick_r     <= 1'b0;
            under_r    <= 1'b0;
            ucnt_r     <= 16'd0;
        end else begin
            tick_r  <= tick_s;
            under_r <= tick_s && empty_s;
            if (pop_s) begin
                cur_code_r <= mem_r[rd_ptr_r];
            end else if (tick_s && (UNDERRUN_HOLD == 0)) begin
                cur_code_r <= MID_CODE;
            end
            if (tick_s && empty_s && (ucnt_r != 16'hFFFF)) begin
                ucnt_r <= ucnt_r + 16'd1;
            end
        end
    end

    // Sigma-delta accumulator, runs every cycle regardless of enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_r <= {CODE_WIDTH{1'b0}};
            pwm_r <= 1'b0;
        end else begin
            acc_r <= sum_s[CODE_WIDTH-1:0];
            pwm_r <= sum_s[CODE_WIDTH];
        end
    end

    assign in_ready       = ready_s;
    assign fill_level     = fill_r;
    assign sample_tick    = tick_r;
    assign underrun       = under_r;
    assign underrun_count = ucnt_r;
    assign pwm_out        = pwm_r;

endmodule

// File: tb/tb_sampler_fifo.sv
// Bench for sampler_fifo: one hold-policy and one mid-scale-policy instance share
// stimulus; a queue-based reference model predicts ticks, underruns and pwm_out.
module tb_sampler_fifo;

    localparam int W     = 4;
    localparam int DIV   = 8;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic in_valid = 1'b0;
    logic [W-1:0] in_code = '0;

    logic        rdy  [2];
    logic [2:0]  fill [2];
    logic        tick [2];
    logic        und  [2];
    logic [15:0] ucnt [2];
    logic        pwm  [2];

    sampler_fifo #(.CODE_WIDTH(W), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .UNDERRUN_HOLD(1)) dut_hold (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_code(in_code),
        .in_ready(rdy[0]), .fill_level(fill[0]), .sample_tick(tick[0]), .underrun(und[0]),
        .underrun_count(ucnt[0]), .pwm_out(pwm[0]));

    sampler_fifo #(.CODE_WIDTH(W), .CLK_DIV(DIV), .FIFO_DEPTH(DEPTH), .UNDERRUN_HOLD(0)) dut_mid (
        .clk(clk), .rst(rst), .enable(enable), .in_valid(in_valid), .in_code(in_code),
        .in_ready(rdy[1]), .fill_level(fill[1]), .sample_tick(tick[1]), .underrun(und[1]),
        .underrun_count(ucnt[1]), .pwm_out(pwm[1]));

    always #5 clk = ~clk;

    typedef struct {
        bit und;
        int cnt;
    } ev_t;

    int   m_q[$];
    int   m_cnt;
    int   m_cur [2];
    int   m_acc [2];
    int   m_pwm [2];
    int   m_ucnt[2];
    ev_t  sb0[$];
    ev_t  sb1[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            m_cur[i] = 0; m_acc[i] = 0; m_pwm[i] = 0; m_ucnt[i] = 0;
        end
        sb0.delete();
        sb1.delete();
    endtask

    // One clock edge of the reference: sigma-delta on the old code, then tick, then push.
    task automatic model_step(input bit en, input bit push, input int code);
        bit  tk;
        bit  was_empty;
        int  sum;
        int  head;
        ev_t e;
        tk = en && (m_cnt == DIV - 1);
        was_empty = (m_q.size() == 0);
        for (int i = 0; i < 2; i++) begin
            sum = m_acc[i] + m_cur[i];
            m_pwm[i] = (sum >= (1 << W)) ? 1 : 0;
            m_acc[i] = sum % (1 << W);
        end
        if (tk) begin
            if (was_empty) begin
                for (int i = 0; i < 2; i++)
                    if (m_ucnt[i] < 65535) m_ucnt[i]++;
                m_cur[1] = 1 << (W - 1);
            end else begin
                head = m_q.pop_front();
                m_cur[0] = head;
                m_cur[1] = head;
            end
            e.und = was_empty;
            e.cnt = m_ucnt[0];
            sb0.push_back(e);
            e.cnt = m_ucnt[1];
            sb1.push_back(e);
        end
        if (push) m_q.push_back(code);
        if (en) m_cnt = (m_cnt + 1) % DIV;
    endtask

    task automatic step(input bit en, input bit v, input int code);
        bit push;
        enable   = en;
        in_valid = v;
        in_code  = code[W-1:0];
        push = v && rst && (m_q.size() < DEPTH);
        @(posedge clk);
        model_step(en, push, code);
        #2;
    endtask

    task automatic mon(input int i);
        ev_t e;
        int  n;
        n = (i == 0) ? sb0.size() : sb1.size();
        if (tick[i]) begin
            checks++;
            if (n == 0) begin
                failures++;
                $display("FAIL tick_extra%0d actual=1 expected=0 at %0t", i, $time);
            end else begin
                if (i == 0) e = sb0.pop_front();
                else        e = sb1.pop_front();
                chk($sformatf("underrun_at_tick%0d", i), int'(und[i]), int'(e.und));
                chk($sformatf("ucnt_at_tick%0d", i), int'(ucnt[i]), e.cnt);
            end
        end else begin
            chk($sformatf("tick_missing%0d", i), n, 0);
            chk($sformatf("underrun_stray%0d", i), int'(und[i]), 0);
            if (i == 0) sb0.delete();
            else        sb1.delete();
        end
        chk($sformatf("pwm%0d", i), int'(pwm[i]), m_pwm[i]);
        chk($sformatf("fill%0d", i), int'(fill[i]), m_q.size());
        chk($sformatf("ready%0d", i), int'(rdy[i]), (rst && m_q.size() < DEPTH) ? 1 : 0);
        chk($sformatf("ucnt%0d", i), int'(ucnt[i]), m_ucnt[i]);
    endtask

    // Monitor: compares every DUT output on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            mon(0);
            mon(1);
        end
    end

    initial begin
        int guard;
        model_reset();
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // idle with enable: an underrun every period
        repeat (24) step(1, 0, 0);
        chk("idle_ucnt_hold", int'(ucnt[0]), 3);
        chk("idle_ucnt_mid", int'(ucnt[1]), 3);

        // single codes: mid-scale, near full-scale, zero
        step(0, 1, 8);
        repeat (40) step(1, 0, 0);
        step(1, 1, 15);
        repeat (40) step(1, 0, 0);
        step(1, 1, 0);
        repeat (40) step(1, 0, 0);

        // fill while paused, fifth push refused, then resume
        for (int k = 0; k < 5; k++) step(0, 1, k + 3);
        chk("full_fill", int'(fill[0]), 4);
        chk("full_ready", int'(rdy[0]), 0);
        repeat (40) step(1, 0, 0);

        // push exactly on the tick of an empty FIFO
        guard = 0;
        while (!(m_cnt == DIV - 1 && m_q.size() == 0) && guard < 100) begin
            step(1, 0, 0);
            guard++;
        end
        chk("align_guard", (guard < 100) ? 1 : 0, 1);
        step(1, 1, 3);
        chk("tick_push_fill", int'(fill[0]), 1);
        repeat (16) step(1, 0, 0);

        // drain after code 12: hold vs mid-scale policies diverge
        step(1, 1, 12);
        repeat (32) step(1, 0, 0);

        // asynchronous reset mid-period with three entries queued
        for (int k = 0; k < 3; k++) step(0, 1, 9 + k);
        step(1, 0, 0);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("arst_fill%0d", i), int'(fill[i]), 0);
            chk($sformatf("arst_ready%0d", i), int'(rdy[i]), 0);
            chk($sformatf("arst_ucnt%0d", i), int'(ucnt[i]), 0);
            chk($sformatf("arst_pwm%0d", i), int'(pwm[i]), 0);
            chk($sformatf("arst_tick%0d", i), int'(tick[i]), 0);
            chk($sformatf("arst_und%0d", i), int'(und[i]), 0);
        end
        model_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        repeat (8) step(1, 0, 0);
        chk("post_reset_ucnt", int'(ucnt[0]), 1);

        // randomized traffic: roughly balanced, then oversubscribed
        repeat (1500) step($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 15));
        repeat (1500) step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 0, $urandom_range(0, 15));
        repeat (2) step(1, 0, 0);
        chk("sb0_drained", sb0.size(), 0);
        chk("sb1_drained", sb1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
